// File: rtl/aucohl_pwm_tmr_nch.sv
// Multi-channel PWM timer: one shared prescaled up/down/up-down counter feeding
// CHANNELS shadowed compare units with polarity control and a latching fault override.
module aucohl_pwm_tmr_nch #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int PW       = 8
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic                      one_shot,
    input  logic                      restart,
    input  logic [PW-1:0]             prescale,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] cmp,
    input  logic [CHANNELS-1:0]       pol,
    input  logic                      fault,
    input  logic                      fault_en,
    input  logic                      fault_clr,
    input  logic [CHANNELS-1:0]       fault_level,
    output logic [WIDTH-1:0]          cnt,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      timeout_flag,
    output logic [CHANNELS-1:0]       cmp_match,
    output logic                      fault_active,
    output logic                      running
);

    localparam logic [1:0] M_UP   = 2'b00;
    localparam logic [1:0] M_DOWN = 2'b01;
    localparam logic [1:0] M_UPDN = 2'b10;

    logic [PW-1:0]             presc_q, presc_d;
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]          per_q, per_d;
    logic [CHANNELS*WIDTH-1:0] cmp_q, cmp_d;
    logic                      dir_q, dir_d;     // 1 = counting down (up-down mode)
    logic                      done_q, done_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic [CHANNELS-1:0]       eq_q, eq_d;
    logic [CHANNELS-1:0]       match_q, match_d;
    logic                      tmo_q, tmo_d;
    logic                      fault_q, fault_d;
    logic                      fs1_q, fs_q;

    logic       run, tick, term, load, force_lvl;
    logic [1:0] mode_e;

    always_comb begin
        mode_e  = (mode == 2'b11) ? M_UP : mode;
        run     = en && !done_q;
        tick    = run && (presc_q == prescale) && !restart;
        presc_d = presc_q + 1'b1;
        if (!en || restart || (presc_q == prescale))
            presc_d = '0;

        term   = 1'b0;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        done_d = done_q;
        if (restart) begin
            cnt_d  = (mode_e == M_DOWN) ? period : '0;
            dir_d  = 1'b0;
            done_d = 1'b0;
        end else if (tick) begin
            case (mode_e)
                M_DOWN: begin
                    if (cnt_q == '0) begin
                        term  = 1'b1;
                        cnt_d = one_shot ? cnt_q : period;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                M_UPDN: begin
                    if (dir_q) begin
                        if (cnt_q == '0) begin
                            term = 1'b1;
                            if (!one_shot) begin
                                dir_d = 1'b0;
                                // Next period length comes from the shadow reloaded on this edge.
                                cnt_d = (period == '0) ? '0 : cnt_q + 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end else if (per_q == '0) begin
                        term = 1'b1;
                    end else if (cnt_q == per_q) begin
                        dir_d = 1'b1;
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == per_q) begin
                        term  = 1'b1;
                        cnt_d = one_shot ? cnt_q : '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
            if (term && one_shot)
                done_d = 1'b1;
        end
        tmo_d = term;

        load  = restart || !en || term;
        per_d = load ? period : per_q;
        cmp_d = load ? cmp : cmp_q;
    end

    always_comb begin
        force_lvl = fault_q || (fs_q && fault_en);
        eq_d      = '0;
        pwm_d     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            eq_d[i]  = (cnt_q == cmp_q[i*WIDTH +: WIDTH]);
            pwm_d[i] = (cnt_q < cmp_q[i*WIDTH +: WIDTH]) ^ pol[i];
        end
        if (force_lvl)
            pwm_d = fault_level;
        match_d = eq_d & ~eq_q;

        // A new set outranks a clear; a clear is honoured only once the request is gone.
        fault_d = fault_q;
        if (fs_q && fault_en)
            fault_d = 1'b1;
        else if (fault_clr && !fs_q)
            fault_d = 1'b0;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            presc_q <= '0;
            cnt_q   <= '0;
            per_q   <= '0;
            cmp_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            pwm_q   <= '0;
            eq_q    <= '1;  // reset count 0 already equals reset compare 0
            match_q <= '0;
            tmo_q   <= 1'b0;
            fault_q <= 1'b0;
            fs1_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            cmp_q   <= cmp_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            pwm_q   <= pwm_d;
            eq_q    <= eq_d;
            match_q <= match_d;
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
            fs1_q   <= fault;
            fs_q    <= fs1_q;
        end
    end

    assign cnt          = cnt_q;
    assign pwm          = pwm_q;
    assign timeout_flag = tmo_q;
    assign cmp_match    = match_q;
    assign fault_active = fault_q;
    assign running      = run;

endmodule

// File: tb/tb_aucohl_pwm_tmr_nch.sv
// Directed bench for aucohl_pwm_tmr_nch: up, up-down, shadowing, one-shot, fault and async reset.
module tb_aucohl_pwm_tmr_nch;

    localparam int W  = 32;
    localparam int CH = 4;
    localparam int PW = 8;

    logic            PCLK = 1'b0;
    logic            PRESET;
    logic            en, one_shot, restart, fault, fault_en, fault_clr;
    logic [1:0]      mode;
    logic [PW-1:0]   prescale;
    logic [W-1:0]    period;
    logic [CH*W-1:0] cmp;
    logic [CH-1:0]   pol, fault_level;
    logic [W-1:0]    cnt;
    logic [CH-1:0]   pwm, cmp_match;
    logic            timeout_flag, fault_active, running;

    int nvec = 0;
    int nerr = 0;

    aucohl_pwm_tmr_nch #(.WIDTH(W), .CHANNELS(CH), .PW(PW)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .en(en), .mode(mode), .one_shot(one_shot),
        .restart(restart), .prescale(prescale), .period(period), .cmp(cmp), .pol(pol),
        .fault(fault), .fault_en(fault_en), .fault_clr(fault_clr), .fault_level(fault_level),
        .cnt(cnt), .pwm(pwm), .timeout_flag(timeout_flag), .cmp_match(cmp_match),
        .fault_active(fault_active), .running(running)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    function automatic int ud_seq(input int n);
        int m;
        m = n % 8;
        return (m <= 4) ? m : 8 - m;
    endfunction

    initial begin
        PRESET = 1'b1; en = 1'b0; mode = 2'b00; one_shot = 1'b0; restart = 1'b0;
        prescale = '0; period = 32'd9; cmp = {32'd12, 32'd0, 32'd5, 32'd3};
        pol = 4'b0000; fault = 1'b0; fault_en = 1'b0; fault_clr = 1'b0; fault_level = 4'b1010;
        step();
        chk("rst_cnt", cnt, 32'd0);
        chk("rst_pwm", 32'(pwm), 32'd0);
        chk("rst_tmo", 32'(timeout_flag), 32'd0);
        chk("rst_match", 32'(cmp_match), 32'd0);
        chk("rst_fault", 32'(fault_active), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        PRESET = 1'b0;
        step();
        step();

        // Up mode, period 9, cmp0=3, ch2 cmp 0 (always low), ch3 cmp 12 (always high)
        en = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            step();
            chk("up_cnt", cnt, 32'(n % 10));
            chk("up_pwm0", 32'(pwm[0]), 32'(((n - 1) % 10) < 3));
            chk("up_pwm2", 32'(pwm[2]), 32'd0);
            chk("up_pwm3", 32'(pwm[3]), 32'd1);
            chk("up_tmo", 32'(timeout_flag), 32'((n % 10) == 0));
            chk("up_match0", 32'(cmp_match[0]), 32'(((n - 1) % 10) == 3));
        end

        // Up-down mode, period 4, cmp1=2 with inverted polarity
        en = 1'b0; mode = 2'b10; period = 32'd4; cmp = {32'd12, 32'd0, 32'd2, 32'd3};
        pol = 4'b0010; restart = 1'b1;
        step();
        restart = 1'b0; en = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            chk("ud_cnt", cnt, 32'(ud_seq(n)));
            chk("ud_tmo", 32'(timeout_flag), 32'((n % 8) == 1 && n > 1));
            chk("ud_pwm1", 32'(pwm[1]), 32'(!(ud_seq(n - 1) < 2)));
        end

        // Shadowed period: change 9 -> 4 mid-period takes effect after the next timeout
        mode = 2'b00; period = 32'd9; restart = 1'b1;
        step();
        restart = 1'b0;
        chk("sh_restart_cnt", cnt, 32'd0);
        for (int n = 1; n <= 16; n++) begin
            step();
            if (n == 5) period = 32'd4;
            chk("sh_cnt", cnt, 32'((n <= 10) ? (n % 10) : ((n - 10) % 5)));
            chk("sh_tmo", 32'(timeout_flag), 32'(n == 10 || n == 15));
        end

        // One-shot down mode, period 3, two cycles per count step
        mode = 2'b01; one_shot = 1'b1; prescale = 8'd1; period = 32'd3; restart = 1'b1;
        step();
        restart = 1'b0;
        chk("os_start_cnt", cnt, 32'd3);
        for (int n = 1; n <= 12; n++) begin
            step();
            chk("os_cnt", cnt, 32'((n < 2) ? 3 : (n < 4) ? 2 : (n < 6) ? 1 : 0));
            chk("os_tmo", 32'(timeout_flag), 32'(n == 8));
            chk("os_running", 32'(running), 32'(n < 8));
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("os_rs_cnt", cnt, 32'd3);
        chk("os_rs_running", 32'(running), 32'd1);
        one_shot = 1'b0;

        // Fault override; normal levels are constant: ch0,ch3 low, ch1,ch2 high
        mode = 2'b00; prescale = '0; period = 32'd9; cmp = {32'd0, 32'd12, 32'd12, 32'd0};
        pol = 4'b0000; restart = 1'b1;
        step();
        restart = 1'b0;
        step();
        step();
        chk("fl_norm_pwm", 32'(pwm), 32'b0110);
        fault_en = 1'b1; fault = 1'b1;
        step();
        chk("fl_k_pwm", 32'(pwm), 32'b0110);
        chk("fl_k_act", 32'(fault_active), 32'd0);
        step();
        chk("fl_k1_pwm", 32'(pwm), 32'b0110);
        chk("fl_k1_act", 32'(fault_active), 32'd0);
        step();
        chk("fl_k2_pwm", 32'(pwm), 32'b1010);
        chk("fl_k2_act", 32'(fault_active), 32'd1);
        fault_en = 1'b0; fault_clr = 1'b1;
        step();
        chk("fl_clr_ign_act", 32'(fault_active), 32'd1);
        chk("fl_clr_ign_pwm", 32'(pwm), 32'b1010);
        fault_clr = 1'b0; fault = 1'b0; fault_en = 1'b1;
        step();
        step();
        chk("fl_hold_act", 32'(fault_active), 32'd1);
        chk("fl_hold_pwm", 32'(pwm), 32'b1010);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("fl_clr_act", 32'(fault_active), 32'd0);
        chk("fl_clr_pwm", 32'(pwm), 32'b1010);
        step();
        chk("fl_resume_pwm", 32'(pwm), 32'b0110);
        chk("fl_resume_act", 32'(fault_active), 32'd0);

        // Async reset mid-cycle with the fault latched
        fault = 1'b1;
        step();
        step();
        step();
        chk("ar_pre_act", 32'(fault_active), 32'd1);
        chk("ar_pre_cnt", cnt, 32'd3);
        #2;
        PRESET = 1'b1; en = 1'b0; fault = 1'b0;
        #1;
        chk("ar_cnt", cnt, 32'd0);
        chk("ar_pwm", 32'(pwm), 32'd0);
        chk("ar_act", 32'(fault_active), 32'd0);
        chk("ar_tmo", 32'(timeout_flag), 32'd0);
        step();
        PRESET = 1'b0;
        step();
        chk("ar_idle_cnt", cnt, 32'd0);
        en = 1'b1;
        step();
        chk("ar_run1_cnt", cnt, 32'd1);
        step();
        chk("ar_run2_cnt", cnt, 32'd2);
        chk("ar_run_act", 32'(fault_active), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
